// File: rtl/cache_mem_dm_ctrl_if.sv
// Requester, response and backing-memory signals of the
// direct-mapped write-through cache controller.
interface cache_mem_dm_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_hit;
    logic              flush;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, flush,
        input  mem_rdata, mem_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_hit,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, flush,
        output mem_rdata, mem_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_hit,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_mem_dm_ctrl.sv
// Direct-mapped, one-word-line, write-through / write-no-allocate
// cache controller with miss refill, flush and hit/miss counters.
module cache_mem_dm_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LINES  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    cache_mem_dm_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, RESP} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [DATA_W-1:0]  data_q [LINES];
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               hit_q, hit_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic               mem_rd_en_q, mem_rd_en_d;
    logic               mem_wr_en_q, mem_wr_en_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]   req_idx, lat_idx, line_idx;
    logic [TAG_W-1:0]   req_tag, line_tag;
    logic [DATA_W-1:0]  line_data;
    logic               line_we, lookup_hit, accept;

    assign req_idx    = bus.req_addr[IDX_W-1:0];
    assign req_tag    = bus.req_addr[ADDR_W-1:IDX_W];
    assign lat_idx    = addr_q[IDX_W-1:0];
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign bus.req_ready = (state_q == IDLE) && !bus.flush && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.mem_rd_en = mem_rd_en_q;
    assign bus.mem_wr_en = mem_wr_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;

    // Next-state: lookup on accept, memory handshakes, one-cycle response.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        hit_d       = hit_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_hit_d   = 1'b0;
        mem_rd_en_d = mem_rd_en_q;
        mem_wr_en_d = mem_wr_en_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        line_we     = 1'b0;
        line_idx    = req_idx;
        line_tag    = req_tag;
        line_data   = bus.req_wdata;
        unique case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end else if (accept) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    hit_d   = lookup_hit;
                    if (lookup_hit) begin
                        if (hit_cnt_q != '1)
                            hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end else if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                    if (bus.req_wr) begin
                        // Write hit keeps the line coherent with memory.
                        line_we     = lookup_hit;
                        mem_wr_en_d = 1'b1;
                        state_d     = MEM_WR;
                    end else if (lookup_hit) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = data_q[req_idx];
                        rsp_hit_d   = 1'b1;
                        state_d     = RESP;
                    end else begin
                        mem_rd_en_d = 1'b1;
                        state_d     = MEM_RD;
                    end
                end
            end
            MEM_RD: begin
                if (bus.mem_ack) begin
                    line_we           = 1'b1;
                    line_idx          = lat_idx;
                    line_tag          = addr_q[ADDR_W-1:IDX_W];
                    line_data         = bus.mem_rdata;
                    valid_d[lat_idx]  = 1'b1;
                    rsp_valid_d       = 1'b1;
                    rsp_rdata_d       = bus.mem_rdata;
                    rsp_hit_d         = hit_q;
                    mem_rd_en_d       = 1'b0;
                    state_d           = RESP;
                end
            end
            MEM_WR: begin
                if (bus.mem_ack) begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = hit_q;
                    mem_wr_en_d = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered outputs; reset abandons any memory access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            hit_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_hit_q   <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            hit_q       <= hit_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_hit_q   <= rsp_hit_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag and data storage; contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (line_we && !rst) begin
            tag_q[line_idx]  <= line_tag;
            data_q[line_idx] <= line_data;
        end
    end
endmodule

// File: tb/tb_cache_mem_dm_ctrl.sv
// Randomised self-checking bench for cache_mem_dm_ctrl against a
// behavioural cache model and a backing-memory responder.
module tb_cache_mem_dm_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_mem_dm_ctrl_if #(.DATA_W(8), .ADDR_W(8)) b1 ();
    cache_mem_dm_ctrl_if #(.DATA_W(8), .ADDR_W(8)) b2 ();

    logic [15:0] hc1, mc1;
    logic [3:0]  hc2, mc2;

    cache_mem_dm_ctrl dut (
        .clk(clk), .rst(rst), .bus(b1.slave),
        .hit_cnt(hc1), .miss_cnt(mc1)
    );

    cache_mem_dm_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .bus(b2.slave),
        .hit_cnt(hc2), .miss_cnt(mc2)
    );

    assign b2.req_valid = b1.req_valid;
    assign b2.req_wr    = b1.req_wr;
    assign b2.req_addr  = b1.req_addr;
    assign b2.req_wdata = b1.req_wdata;
    assign b2.flush     = b1.flush;
    assign b2.mem_rdata = b1.mem_rdata;
    assign b2.mem_ack   = b1.mem_ack;

    int nchk = 0;
    int nerr = 0;

    logic [7:0] bmem    [256];
    logic [7:0] ref_mem [256];
    bit         mv      [16];
    logic [3:0] mt      [16];
    int         exp_hit, exp_miss;

    typedef struct {
        bit         ready;
        bit         saw_rd;
        bit         saw_wr;
        bit         both;
        logic [7:0] maddr;
        logic [7:0] mwdata;
        int         ack_cyc;
        int         rsp_cyc;
        logic [7:0] rdata;
        logic       hit;
        bit         timeout;
    } obs_t;

    function automatic void model_clear(bit counts);
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        if (counts) begin
            exp_hit  = 0;
            exp_miss = 0;
        end
    endfunction

    function automatic bit model_access(bit wr, logic [7:0] a, logic [7:0] d);
        bit h;
        h = mv[a[3:0]] && (mt[a[3:0]] == a[7:4]);
        if (h) exp_hit++;
        else   exp_miss++;
        if (wr) begin
            ref_mem[a] = d;
        end else if (!h) begin
            mv[a[3:0]] = 1'b1;
            mt[a[3:0]] = a[7:4];
        end
        return h;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        b1.req_valid = 1'b0;
        b1.flush = 1'b0;
        b1.mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear(1'b1);
    endtask

    task automatic do_tx(input bit wr, input logic [7:0] a,
                         input logic [7:0] d, input int dly,
                         output obs_t o);
        int waited;
        o = '{default: 0};
        waited = 0;
        o.timeout = 1'b1;
        @(negedge clk);
        b1.req_valid = 1'b1;
        b1.req_wr    = wr;
        b1.req_addr  = a;
        b1.req_wdata = d;
        #1 o.ready = b1.req_ready;
        @(posedge clk);
        #1;
        b1.req_valid = 1'b0;
        b1.req_wr    = 1'($urandom);
        b1.req_addr  = 8'($urandom);
        b1.req_wdata = 8'($urandom);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            b1.mem_ack   = 1'b0;
            b1.mem_rdata = 8'($urandom);
            if (b1.rsp_valid) begin
                o.rsp_cyc = c;
                o.rdata   = b1.rsp_rdata;
                o.hit     = b1.rsp_hit;
                o.timeout = 1'b0;
                break;
            end
            if (b1.mem_rd_en || b1.mem_wr_en) begin
                if (b1.mem_rd_en) o.saw_rd = 1'b1;
                if (b1.mem_wr_en) o.saw_wr = 1'b1;
                if (b1.mem_rd_en && b1.mem_wr_en) o.both = 1'b1;
                o.maddr  = b1.mem_addr;
                o.mwdata = b1.mem_wdata;
                if (waited == dly) begin
                    b1.mem_ack = 1'b1;
                    o.ack_cyc  = c;
                    if (b1.mem_rd_en) b1.mem_rdata = bmem[b1.mem_addr];
                    else bmem[b1.mem_addr] = b1.mem_wdata;
                end else begin
                    waited++;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        nchk++; if (b1.req_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready_in_reset: got %0b want 0", b1.req_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_clear(1'b1);
        #1;
        nchk++; if (b1.req_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %0b want 1", b1.req_ready); end
        nchk++; if ({b1.rsp_valid, b1.rsp_hit, b1.mem_rd_en, b1.mem_wr_en} !== 4'b0) begin nerr++; $display("FAIL rst_ctrl: got %b want 0000", {b1.rsp_valid, b1.rsp_hit, b1.mem_rd_en, b1.mem_wr_en}); end
        nchk++; if ({b1.rsp_rdata, b1.mem_addr, b1.mem_wdata} !== 24'h0) begin nerr++; $display("FAIL rst_data: got %h want 0", {b1.rsp_rdata, b1.mem_addr, b1.mem_wdata}); end
        nchk++; if ({hc1, mc1} !== 32'h0) begin nerr++; $display("FAIL rst_cnt: got %h want 0", {hc1, mc1}); end
    endtask

    task automatic test_miss_then_hit();
        obs_t o;
        bit   h;
        bmem[8'h25]    = 8'hA5;
        ref_mem[8'h25] = 8'hA5;
        h = model_access(1'b0, 8'h25, 8'h00);
        do_tx(1'b0, 8'h25, 8'h00, 3, o);
        nchk++; if (o.timeout || !o.ready) begin nerr++; $display("FAIL t1_done: got timeout=%0b ready=%0b want 0/1", o.timeout, o.ready); end
        nchk++; if (!o.saw_rd || o.maddr !== 8'h25) begin nerr++; $display("FAIL t1_memrd: got rd=%0b addr=%h want 1/25", o.saw_rd, o.maddr); end
        nchk++; if (o.rdata !== 8'hA5 || o.hit !== h) begin nerr++; $display("FAIL t1_rsp: got %h hit=%0b want a5 hit=%0b", o.rdata, o.hit, h); end
        nchk++; if (o.rsp_cyc != o.ack_cyc + 1 || o.ack_cyc != 4) begin nerr++; $display("FAIL t1_lat: got ack=%0d rsp=%0d want 4/5", o.ack_cyc, o.rsp_cyc); end
        nchk++; if (mc1 !== 16'(exp_miss)) begin nerr++; $display("FAIL t1_miss_cnt: got %0d want %0d", mc1, exp_miss); end
        h = model_access(1'b0, 8'h25, 8'h00);
        do_tx(1'b0, 8'h25, 8'h00, 0, o);
        nchk++; if (o.rsp_cyc != 1 || o.saw_rd) begin nerr++; $display("FAIL t1_hit_lat: got cyc=%0d rd=%0b want 1/0", o.rsp_cyc, o.saw_rd); end
        nchk++; if (o.rdata !== 8'hA5 || o.hit !== h) begin nerr++; $display("FAIL t1_hit_rsp: got %h hit=%0b want a5 hit=%0b", o.rdata, o.hit, h); end
        nchk++; if (hc1 !== 16'(exp_hit)) begin nerr++; $display("FAIL t1_hit_cnt: got %0d want %0d", hc1, exp_hit); end
        // Next request must be accepted at the end of cycle 2.
        h = model_access(1'b0, 8'h25, 8'h00);
        do_tx(1'b0, 8'h25, 8'h00, 0, o);
        nchk++; if (!o.ready || o.rsp_cyc != 1 || o.hit !== h) begin nerr++; $display("FAIL t1_b2b: got ready=%0b cyc=%0d hit=%0b want 1/1/%0b", o.ready, o.rsp_cyc, o.hit, h); end
    endtask

    task automatic test_conflict();
        obs_t o;
        bit   h;
        logic [7:0] seq [3];
        seq[0] = 8'h25;
        seq[1] = 8'h35;
        seq[2] = 8'h25;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] er;
            er = ref_mem[seq[i]];
            h = model_access(1'b0, seq[i], 8'h00);
            do_tx(1'b0, seq[i], 8'h00, i, o);
            nchk++; if (o.hit !== h || !o.saw_rd || o.maddr !== seq[i]) begin nerr++; $display("FAIL t2_miss%0d: got hit=%0b rd=%0b addr=%h want %0b/1/%h", i, o.hit, o.saw_rd, o.maddr, h, seq[i]); end
            nchk++; if (o.rdata !== er) begin nerr++; $display("FAIL t2_data%0d: got %h want %h", i, o.rdata, er); end
        end
        nchk++; if (mc1 !== 16'(exp_miss) || hc1 !== 16'(exp_hit)) begin nerr++; $display("FAIL t2_cnt: got %0d/%0d want %0d/%0d", hc1, mc1, exp_hit, exp_miss); end
    endtask

    task automatic test_write();
        obs_t o;
        bit   h;
        h = model_access(1'b1, 8'h25, 8'h3C);
        do_tx(1'b1, 8'h25, 8'h3C, 2, o);
        nchk++; if (o.hit !== h || !o.saw_wr || o.saw_rd) begin nerr++; $display("FAIL t3_wr_hit: got hit=%0b wr=%0b rd=%0b want %0b/1/0", o.hit, o.saw_wr, o.saw_rd, h); end
        nchk++; if (o.maddr !== 8'h25 || o.mwdata !== 8'h3C) begin nerr++; $display("FAIL t3_wr_bus: got %h=%h want 25=3c", o.maddr, o.mwdata); end
        nchk++; if (o.rdata !== 8'h00 || o.rsp_cyc != o.ack_cyc + 1) begin nerr++; $display("FAIL t3_wr_rsp: got %h cyc=%0d want 00 cyc=%0d", o.rdata, o.rsp_cyc, o.ack_cyc + 1); end
        h = model_access(1'b0, 8'h25, 8'h00);
        do_tx(1'b0, 8'h25, 8'h00, 0, o);
        nchk++; if (o.hit !== h || o.rdata !== 8'h3C || o.saw_rd) begin nerr++; $display("FAIL t3_rd_hit: got hit=%0b %h rd=%0b want %0b 3c 0", o.hit, o.rdata, o.saw_rd, h); end
        h = model_access(1'b1, 8'h40, 8'h5A);
        do_tx(1'b1, 8'h40, 8'h5A, 1, o);
        nchk++; if (o.hit !== h || o.mwdata !== 8'h5A || o.maddr !== 8'h40) begin nerr++; $display("FAIL t3_wr_miss: got hit=%0b %h=%h want %0b 40=5a", o.hit, o.maddr, o.mwdata, h); end
        h = model_access(1'b0, 8'h40, 8'h00);
        do_tx(1'b0, 8'h40, 8'h00, 0, o);
        nchk++; if (o.hit !== h || !o.saw_rd || o.rdata !== 8'h5A) begin nerr++; $display("FAIL t3_no_alloc: got hit=%0b rd=%0b %h want %0b 1 5a", o.hit, o.saw_rd, o.rdata, h); end
    endtask

    task automatic test_flush();
        obs_t o;
        bit   h;
        h = model_access(1'b0, 8'h25, 8'h00);
        do_tx(1'b0, 8'h25, 8'h00, 0, o);
        nchk++; if (o.hit !== h) begin nerr++; $display("FAIL t4_cached: got hit=%0b want %0b", o.hit, h); end
        @(negedge clk);
        b1.flush     = 1'b1;
        b1.req_valid = 1'b1;
        b1.req_wr    = 1'b0;
        b1.req_addr  = 8'h25;
        #1;
        nchk++; if (b1.req_ready !== 1'b0) begin nerr++; $display("FAIL t4_ready: got %0b want 0", b1.req_ready); end
        @(posedge clk);
        #1;
        b1.flush     = 1'b0;
        b1.req_valid = 1'b0;
        model_clear(1'b0);
        @(negedge clk);
        nchk++; if ({b1.rsp_valid, b1.mem_rd_en} !== 2'b00) begin nerr++; $display("FAIL t4_idle: got %b want 00", {b1.rsp_valid, b1.mem_rd_en}); end
        h = model_access(1'b0, 8'h25, 8'h00);
        do_tx(1'b0, 8'h25, 8'h00, 1, o);
        nchk++; if (o.hit !== h || !o.saw_rd || o.rdata !== ref_mem[8'h25]) begin nerr++; $display("FAIL t4_miss: got hit=%0b rd=%0b %h want %0b 1 %h", o.hit, o.saw_rd, o.rdata, h, ref_mem[8'h25]); end
        nchk++; if (mc1 !== 16'(exp_miss) || hc1 !== 16'(exp_hit)) begin nerr++; $display("FAIL t4_cnt: got %0d/%0d want %0d/%0d", hc1, mc1, exp_hit, exp_miss); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   h;
        h = model_access(1'b0, 8'h25, 8'h00);
        do_tx(1'b0, 8'h25, 8'h00, 0, o);
        @(negedge clk);
        b1.req_valid = 1'b1;
        b1.req_wr    = 1'b0;
        b1.req_addr  = 8'h77;
        @(posedge clk);
        #1 b1.req_valid = 1'b0;
        @(negedge clk);
        nchk++; if (b1.mem_rd_en !== 1'b1) begin nerr++; $display("FAIL t5_pending: got %0b want 1", b1.mem_rd_en); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear(1'b1);
        #1;
        nchk++; if (b1.mem_rd_en !== 1'b0 || b1.req_ready !== 1'b1) begin nerr++; $display("FAIL t5_abandon: got rd=%0b ready=%0b want 0/1", b1.mem_rd_en, b1.req_ready); end
        nchk++; if ({hc1, mc1} !== 32'h0) begin nerr++; $display("FAIL t5_cnt: got %h want 0", {hc1, mc1}); end
        h = model_access(1'b0, 8'h25, 8'h00);
        do_tx(1'b0, 8'h25, 8'h00, 0, o);
        nchk++; if (o.hit !== h || !o.saw_rd) begin nerr++; $display("FAIL t5_miss: got hit=%0b rd=%0b want %0b/1", o.hit, o.saw_rd, h); end
    endtask

    task automatic test_saturate();
        obs_t o;
        bit   h;
        apply_reset();
        h = model_access(1'b0, 8'h11, 8'h00);
        do_tx(1'b0, 8'h11, 8'h00, 0, o);
        for (int i = 0; i < 17; i++) begin
            h = model_access(1'b0, 8'h11, 8'h00);
            do_tx(1'b0, 8'h11, 8'h00, 0, o);
        end
        nchk++; if (hc2 !== 4'd15 || mc2 !== 4'd1) begin nerr++; $display("FAIL t6_sat: got %0d/%0d want 15/1", hc2, mc2); end
        nchk++; if (hc1 !== 16'(exp_hit) || mc1 !== 16'(exp_miss)) begin nerr++; $display("FAIL t6_wide: got %0d/%0d want %0d/%0d", hc1, mc1, exp_hit, exp_miss); end
    endtask

    task automatic test_random();
        obs_t o;
        bit   h, wr;
        int   dly, ecyc;
        logic [7:0] a, d, er;
        apply_reset();
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                @(negedge clk);
                b1.flush     = 1'b1;
                b1.req_valid = 1'b1;
                #1;
                nchk++; if (b1.req_ready !== 1'b0) begin nerr++; $display("FAIL rnd_flush_ready: n=%0d got %0b want 0", n, b1.req_ready); end
                @(posedge clk);
                #1;
                b1.flush     = 1'b0;
                b1.req_valid = 1'b0;
                model_clear(1'b0);
            end
            wr  = ($urandom_range(0, 3) == 0);
            a   = 8'($urandom_range(0, 3) * 16 + $urandom_range(0, 7));
            d   = 8'($urandom);
            dly = $urandom_range(0, 3);
            er  = wr ? 8'h00 : ref_mem[a];
            h   = model_access(wr, a, d);
            do_tx(wr, a, d, dly, o);
            ecyc = (wr || !h) ? o.ack_cyc + 1 : 1;
            nchk++; if (o.timeout || !o.ready) begin nerr++; $display("FAIL rnd_done: n=%0d got timeout=%0b ready=%0b", n, o.timeout, o.ready); end
            nchk++; if (o.hit !== h) begin nerr++; $display("FAIL rnd_hit: n=%0d a=%h got %0b want %0b", n, a, o.hit, h); end
            nchk++; if (o.rdata !== er) begin nerr++; $display("FAIL rnd_rdata: n=%0d a=%h got %h want %h", n, a, o.rdata, er); end
            nchk++; if (o.saw_rd !== (!wr && !h) || o.saw_wr !== wr || o.both) begin nerr++; $display("FAIL rnd_mem_kind: n=%0d got rd=%0b wr=%0b want %0b/%0b", n, o.saw_rd, o.saw_wr, !wr && !h, wr); end
            nchk++; if ((wr || !h) && o.maddr !== a) begin nerr++; $display("FAIL rnd_maddr: n=%0d got %h want %h", n, o.maddr, a); end
            nchk++; if (wr && o.mwdata !== d) begin nerr++; $display("FAIL rnd_mwdata: n=%0d got %h want %h", n, o.mwdata, d); end
            nchk++; if (o.rsp_cyc != ecyc || ((wr || !h) && o.ack_cyc != dly + 1)) begin nerr++; $display("FAIL rnd_lat: n=%0d got rsp=%0d ack=%0d want %0d/%0d", n, o.rsp_cyc, o.ack_cyc, ecyc, dly + 1); end
            nchk++; if (hc1 !== 16'(exp_hit) || mc1 !== 16'(exp_miss)) begin nerr++; $display("FAIL rnd_cnt: n=%0d got %0d/%0d want %0d/%0d", n, hc1, mc1, exp_hit, exp_miss); end
        end
    endtask

    initial begin
        b1.req_valid = 1'b0;
        b1.req_wr    = 1'b0;
        b1.req_addr  = '0;
        b1.req_wdata = '0;
        b1.flush     = 1'b0;
        b1.mem_rdata = '0;
        b1.mem_ack   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bmem[i]    = 8'($urandom);
            ref_mem[i] = bmem[i];
        end
        model_clear(1'b1);
        repeat (2) @(negedge clk);
        test_reset();
        test_miss_then_hit();
        test_conflict();
        test_write();
        test_flush();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
